// File: rtl/maj2_sweep_checker_pkg.sv
// Shared types and constants for the 2x2-bit exhaustive sweep checker.
// Holds the FSM encoding, vector/response widths and the golden-table slot helper.
package maj2_sweep_checker_pkg;

    localparam int unsigned NUM_VEC = 16;
    localparam int unsigned VEC_W   = 4;
    localparam int unsigned G_W     = 2;
    localparam int unsigned ERR_W   = 5;
    localparam int unsigned SIG_W   = NUM_VEC * G_W;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFin
    } state_e;

    // Extract the 2-bit entry for vector k from a table laid out like the response signature.
    function automatic logic [G_W-1:0] g_slot(input logic [SIG_W-1:0] tab,
                                              input logic [VEC_W-1:0] k);
        return tab[k*G_W +: G_W];
    endfunction

endpackage

// File: rtl/maj2_sweep_checker_if.sv
// Stimulus/response and result bundle between the sweep checker and its environment.
// The checker takes the slave view; the environment hosting the DUT takes the master view.
interface maj2_sweep_checker_if;
    import maj2_sweep_checker_pkg::*;

    logic             start;
    logic [G_W-1:0]   dut_g;
    logic [1:0]       dut_a;
    logic [1:0]       dut_b;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [VEC_W-1:0] fail_idx;
    logic [SIG_W-1:0] resp_sig;

    modport master (
        output start, dut_g,
        input  dut_a, dut_b, busy, done, pass, err_count, fail_idx, resp_sig
    );

    modport slave (
        input  start, dut_g,
        output dut_a, dut_b, busy, done, pass, err_count, fail_idx, resp_sig
    );

endinterface

// File: rtl/maj2_vec_gen.sv
// Vector index and hold counter: steps k every SETTLE enabled cycles.
// last_hold marks the sample cycle of the current vector; last_vec marks k == 15.
module maj2_vec_gen
    import maj2_sweep_checker_pkg::*;
#(
    parameter int unsigned SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [VEC_W-1:0] k,
    output logic             last_hold,
    output logic             last_vec
);

    // Keep at least one bit so SETTLE == 1 still builds a legal counter.
    localparam int unsigned HOLD_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [VEC_W-1:0]  k_q, k_d;

    assign k         = k_q;
    assign last_hold = (hold_q == HOLD_W'(SETTLE - 1));
    assign last_vec  = (k_q == VEC_W'(NUM_VEC - 1));

    always_comb begin
        hold_d = hold_q;
        k_d    = k_q;
        if (clr) begin
            hold_d = '0;
            k_d    = '0;
        end else if (en) begin
            if (last_hold) begin
                hold_d = '0;
                k_d    = k_q + VEC_W'(1);
            end else begin
                hold_d = hold_q + HOLD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
            k_q    <= '0;
        end else begin
            hold_q <= hold_d;
            k_q    <= k_d;
        end
    end

endmodule

// File: rtl/maj2_sweep_checker.sv
// Self-test sequencer: sweeps all 16 (A,B) operand pairs into a 2-in/2-bit-out block,
// captures each response, and reports error count, first failing vector and signature.
module maj2_sweep_checker
    import maj2_sweep_checker_pkg::*;
#(
    parameter int unsigned      SETTLE   = 2,
    parameter logic [SIG_W-1:0] EXPECTED = 32'h0000_0000
) (
    input logic                 clk,
    input logic                 rst,
    maj2_sweep_checker_if.slave sweep
);

    state_e           state_q, state_d;
    logic [VEC_W-1:0] k;
    logic             last_hold;
    logic             last_vec;
    logic             running;
    logic             accept;
    logic             sample;
    logic             mismatch;
    logic [ERR_W-1:0] err_q, err_d;
    logic [VEC_W-1:0] fail_q;
    logic [SIG_W-1:0] sig_q;
    logic             pass_q;

    assign running  = (state_q == StRun);
    assign accept   = (state_q == StIdle) && sweep.start;
    assign sample   = running && last_hold;
    assign mismatch = (sweep.dut_g != g_slot(EXPECTED, k));
    assign err_d    = err_q + ERR_W'(mismatch);

    maj2_vec_gen #(
        .SETTLE (SETTLE)
    ) u_vec_gen (
        .clk       (clk),
        .rst       (rst),
        .clr       (accept),
        .en        (running),
        .k         (k),
        .last_hold (last_hold),
        .last_vec  (last_vec)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (sweep.start) state_d = StRun;
            StRun:   if (last_hold && last_vec) state_d = StFin;
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // pass is loaded on the final sample so it is already valid during the done cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q  <= '0;
            fail_q <= '0;
            sig_q  <= '0;
            pass_q <= 1'b0;
        end else if (accept) begin
            err_q  <= '0;
            fail_q <= '0;
            sig_q  <= '0;
            pass_q <= 1'b0;
        end else if (sample) begin
            sig_q[k*G_W +: G_W] <= sweep.dut_g;
            err_q               <= err_d;
            if (mismatch && (err_q == '0)) begin
                fail_q <= k;
            end
            if (last_vec) begin
                pass_q <= (err_d == '0);
            end
        end
    end

    assign sweep.busy      = running;
    assign sweep.done      = (state_q == StFin);
    assign sweep.pass      = pass_q;
    assign sweep.err_count = err_q;
    assign sweep.fail_idx  = fail_q;
    assign sweep.resp_sig  = sig_q;
    assign sweep.dut_a     = running ? k[3:2] : 2'b00;
    assign sweep.dut_b     = running ? k[1:0] : 2'b00;

endmodule

// File: tb/tb_maj2_sweep_checker.sv
// Scoreboard bench for maj2_sweep_checker: two checkers (SETTLE 2 and 1) each drive a
// behavioural 2x2 block with injectable per-vector faults; a negedge monitor checks all outputs.
module tb_maj2_sweep_checker;

    typedef struct packed {
        logic [4:0]  err;
        logic [3:0]  fail;
        logic        pass;
        logic [31:0] sig;
    } res_t;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    function automatic logic [1:0] golden_g(input logic [1:0] a, input logic [1:0] b);
        return {maj3(a[1], b[1], b[0]), maj3(a[0], b[0], a[1])};
    endfunction

    function automatic logic [1:0] slot(input logic [31:0] v, input logic [3:0] k);
        return v[2*k +: 2];
    endfunction

    function automatic logic [31:0] build_gold();
        logic [31:0] t;
        t = '0;
        for (int k = 0; k < 16; k++) begin
            t[2*k +: 2] = golden_g(2'(k >> 2), 2'(k));
        end
        return t;
    endfunction

    localparam logic [31:0] GOLD = build_gold();
    localparam logic [31:0] EXP0 = GOLD;
    localparam logic [31:0] EXP1 = 32'hFFFF_FFFF;
    localparam int          S0   = 2;
    localparam int          S1   = 1;

    // Reference: what a full sweep must report, given the modelled block's fault mask.
    function automatic res_t predict(input logic [31:0] tab, input logic [31:0] mask);
        res_t r;
        r     = '0;
        r.sig = GOLD ^ mask;
        for (int k = 0; k < 16; k++) begin
            if (slot(r.sig, 4'(k)) != slot(tab, 4'(k))) begin
                if (r.err == 0) r.fail = 4'(k);
                r.err = r.err + 5'd1;
            end
        end
        r.pass = (r.err == 0);
        return r;
    endfunction

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mask0 = '0;
    logic [31:0] mask1 = '0;

    always #5 clk = ~clk;

    maj2_sweep_checker_if if0 ();
    maj2_sweep_checker_if if1 ();

    assign if0.dut_g = golden_g(if0.dut_a, if0.dut_b) ^ slot(mask0, {if0.dut_a, if0.dut_b});
    assign if1.dut_g = golden_g(if1.dut_a, if1.dut_b) ^ slot(mask1, {if1.dut_a, if1.dut_b});

    maj2_sweep_checker #(.SETTLE(S0), .EXPECTED(EXP0)) u_dut0 (
        .clk   (clk),
        .rst   (rst),
        .sweep (if0.slave)
    );

    maj2_sweep_checker #(.SETTLE(S1), .EXPECTED(EXP1)) u_dut1 (
        .clk   (clk),
        .rst   (rst),
        .sweep (if1.slave)
    );

    res_t q0[$];
    res_t q1[$];
    res_t last0 = '0;
    res_t last1 = '0;
    res_t e0, e1;
    bit   act0 = 1'b0;
    bit   act1 = 1'b0;
    bit   end0, end1;
    time  t0 = 0;
    time  t1 = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s @%0t: got %0h want %0h", name, $time, got, want);
        end
    endtask

    // Per-cycle view: which vector should be on the bus, and whether busy/done are due.
    task automatic cyc_check(input string tag, input int s, input bit act, input time t,
                             input logic busy, input logic done, input logic pass,
                             input logic [1:0] a, input logic [1:0] b, output bit at_end);
        int         j;
        int         k;
        logic [5:0] want;
        at_end = 1'b0;
        want   = '0;
        if (act) begin
            j = int'(($time - t - 5) / 10);
            if (j < 16 * s) begin
                k    = j / s;
                want = {2'b10, 2'(k >> 2), 2'(k)};
                chk({tag, "_pass_run"}, 64'(pass), 64'(0));
            end else begin
                want   = 6'b01_0000;
                at_end = 1'b1;
            end
        end
        chk({tag, "_ctl"}, 64'({busy, done, a, b}), 64'(want));
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("u0_rst", 64'({if0.busy, if0.done, if0.pass, if0.dut_a, if0.dut_b,
                               if0.err_count, if0.fail_idx, if0.resp_sig}), 64'(0));
            chk("u1_rst", 64'({if1.busy, if1.done, if1.pass, if1.dut_a, if1.dut_b,
                               if1.err_count, if1.fail_idx, if1.resp_sig}), 64'(0));
            q0.delete();
            q1.delete();
            act0  = 1'b0;
            act1  = 1'b0;
            last0 = '0;
            last1 = '0;
        end else begin
            cyc_check("u0", S0, act0, t0, if0.busy, if0.done, if0.pass, if0.dut_a, if0.dut_b,
                      end0);
            if (end0) begin
                chk("u0_sb_depth", 64'(q0.size() > 0), 64'(1));
                if (q0.size() > 0) begin
                    e0 = q0.pop_front();
                    chk("u0_err_count", 64'(if0.err_count), 64'(e0.err));
                    chk("u0_fail_idx", 64'(if0.fail_idx), 64'(e0.fail));
                    chk("u0_pass", 64'(if0.pass), 64'(e0.pass));
                    chk("u0_resp_sig", 64'(if0.resp_sig), 64'(e0.sig));
                    last0 = e0;
                end
                act0 = 1'b0;
            end else if (!act0) begin
                chk("u0_hold", 64'({if0.err_count, if0.fail_idx, if0.pass, if0.resp_sig}),
                    64'({last0.err, last0.fail, last0.pass, last0.sig}));
            end

            cyc_check("u1", S1, act1, t1, if1.busy, if1.done, if1.pass, if1.dut_a, if1.dut_b,
                      end1);
            if (end1) begin
                chk("u1_sb_depth", 64'(q1.size() > 0), 64'(1));
                if (q1.size() > 0) begin
                    e1 = q1.pop_front();
                    chk("u1_err_count", 64'(if1.err_count), 64'(e1.err));
                    chk("u1_fail_idx", 64'(if1.fail_idx), 64'(e1.fail));
                    chk("u1_pass", 64'(if1.pass), 64'(e1.pass));
                    chk("u1_resp_sig", 64'(if1.resp_sig), 64'(e1.sig));
                    last1 = e1;
                end
                act1 = 1'b0;
            end else if (!act1) begin
                chk("u1_hold", 64'({if1.err_count, if1.fail_idx, if1.pass, if1.resp_sig}),
                    64'({last1.err, last1.fail, last1.pass, last1.sig}));
            end
        end
    end

    // Pulse start for one cycle; the edge that samples it opens the expected sweep.
    task automatic launch(input int id, input logic [31:0] mask);
        @(negedge clk);
        if (id == 0) begin
            mask0     = mask;
            if0.start = 1'b1;
        end else begin
            mask1     = mask;
            if1.start = 1'b1;
        end
        @(posedge clk);
        if (id == 0) begin
            t0   = $time;
            act0 = 1'b1;
            q0.push_back(predict(EXP0, mask));
        end else begin
            t1   = $time;
            act1 = 1'b1;
            q1.push_back(predict(EXP1, mask));
        end
        #1;
        if0.start = 1'b0;
        if1.start = 1'b0;
    endtask

    task automatic sweep(input int id, input logic [31:0] mask);
        launch(id, mask);
        repeat (16 * ((id == 0) ? S0 : S1) + 3) @(negedge clk);
    endtask

    logic [31:0] m;
    int          id;

    initial begin
        if0.start = 1'b0;
        if1.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Golden block, golden table.
        sweep(0, 32'h0);
        // Stuck-at-00 block against an all-ones table.
        sweep(1, GOLD);
        // Single fault on vector 6 (A=01, B=10).
        sweep(0, 32'h1 << 12);
        // SETTLE=1 with a block that matches the all-ones table.
        sweep(1, ~GOLD);

        // Async reset in the middle of vector 9, then a clean sweep.
        launch(0, 32'h0);
        repeat (18) @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        sweep(0, 32'h0);

        // start during RUN and on the done cycle must both be ignored.
        launch(0, 32'h3 << 20);
        repeat (4) @(posedge clk);
        #1 if0.start = 1'b1;
        @(posedge clk);
        #1 if0.start = 1'b0;
        repeat (27) @(posedge clk);
        #1 if0.start = 1'b1;
        @(posedge clk);
        #1 if0.start = 1'b0;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            id = int'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                m = 32'($urandom_range(1, 3)) << (2 * $urandom_range(0, 15));
                if (id == 1) m = m ^ ~GOLD;
            end else begin
                m = $urandom;
            end
            sweep(id, m);
        end

        chk("u0_sb_drained", 64'(q0.size()), 64'(0));
        chk("u1_sb_drained", 64'(q1.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
